// File: rtl/dac_pkg.sv
// Shared definitions for the AD9708 DAC transmitter.
// Holds the controller state encoding, the bit positions of the fields
// inside the 32-bit configDac word, and the underrun behaviour constants.
package dac_pkg;

  // Controller states: IDLE parks the DAC clock low, RUN paces samples out.
  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } dac_state_t;

  // configDac field positions.
  localparam int CFG_ENABLE_BIT = 31;
  localparam int CFG_MODE_BIT   = 30;
  localparam int CFG_OFFSET_LSB = 16;
  localparam int CFG_DIV_LSB    = 0;
  localparam int CFG_DIV_WIDTH  = 8;

  // What dac_data does when an update finds no sample waiting.
  localparam logic UNDERRUN_HOLD   = 1'b0;
  localparam logic UNDERRUN_OFFSET = 1'b1;

endpackage

// File: rtl/sync_fifo.sv
// Small single-clock FIFO buffering samples ahead of the DAC.
// Ports:
//   clk, rst      - clock and synchronous active-high reset (empties the FIFO)
//   push, wdata   - write strobe and data (ignored while full)
//   pop, rdata    - read strobe (ignored while empty); rdata shows the head
//   full, empty   - status derived from the registered occupancy count
//   count         - number of stored entries, 0..DEPTH
module sync_fifo #(
  parameter int WIDTH = 12,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [WIDTH-1:0]           wdata,
  input  logic                       pop,
  output logic [WIDTH-1:0]           rdata,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == (AW + 1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  // Storage has no reset; only the pointers and count define validity.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= wdata;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW + 1)'(1);
        2'b01:   count <= count - (AW + 1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/dac_ad9708_tx.sv
// Streams samples from an AXI-Stream style input to an AD9708-class DAC.
// Samples are buffered in a small FIFO, offset-adjusted, and presented on
// dac_data together with a divided-down dac_clk. dac_data changes on the
// falling edge of dac_clk, so it is settled a full half period before the
// rising edge the DAC latches on.
// Ports:
//   clk, rst                       - clock, synchronous active-high reset
//   s_axis_tdata/tvalid/tready     - sample input handshake
//   configDac                      - [31] enable, [30] underrun mode,
//                                    [16+W-1:16] offset, [7:0] half-period DIV
//   dac_clk, dac_data              - registered DAC interface
//   sample_strobe                  - pulse on every dac_data update
//   underrun, underrun_count       - starvation pulse and saturating tally
module dac_ad9708_tx
  import dac_pkg::*;
#(
  parameter int DAC_DATA_WIDTH = 12,
  parameter int FIFO_DEPTH     = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [DAC_DATA_WIDTH-1:0] s_axis_tdata,
  input  logic                      s_axis_tvalid,
  output logic                      s_axis_tready,
  input  logic [31:0]               configDac,
  output logic                      dac_clk,
  output logic [DAC_DATA_WIDTH-1:0] dac_data,
  output logic                      sample_strobe,
  output logic                      underrun,
  output logic [15:0]               underrun_count
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  dac_state_t                state;
  dac_state_t                next_state;
  logic                      enable;
  logic                      mode;
  logic [DAC_DATA_WIDTH-1:0] offset;
  logic [CFG_DIV_WIDTH-1:0]  div;
  logic [CFG_DIV_WIDTH-1:0]  div_active;
  logic [CFG_DIV_WIDTH-1:0]  half_cnt;
  logic                      first_toggle;
  logic                      wrap;
  logic                      update_event;
  logic                      fifo_push;
  logic                      fifo_pop;
  logic                      fifo_full;
  logic                      fifo_empty;
  logic [DAC_DATA_WIDTH-1:0] fifo_head;
  logic [CNT_W-1:0]          fifo_count;
  logic [31:0]               cfg_unused;

  assign enable = configDac[CFG_ENABLE_BIT];
  assign mode   = configDac[CFG_MODE_BIT];
  assign offset = configDac[CFG_OFFSET_LSB +: DAC_DATA_WIDTH];
  assign div    = configDac[CFG_DIV_LSB +: CFG_DIV_WIDTH];
  // Reserved configDac bits have no function.
  assign cfg_unused = configDac;

  // tready comes straight from the registered occupancy, so a pop in the
  // same cycle does not reopen a full FIFO.
  assign s_axis_tready = (fifo_count != CNT_W'(FIFO_DEPTH));
  assign fifo_push     = s_axis_tvalid && !fifo_full;
  assign fifo_pop      = update_event && !fifo_empty;

  sync_fifo #(
    .WIDTH (DAC_DATA_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fifo_push),
    .wdata (s_axis_tdata),
    .pop   (fifo_pop),
    .rdata (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // An update happens when the half-period counter wraps while dac_clk is
  // high (falling edge), or on the very first wrap after entering RUN so
  // the DAC gets data immediately instead of waiting a whole period.
  always_comb begin
    next_state   = state;
    wrap         = 1'b0;
    update_event = 1'b0;
    case (state)
      IDLE: begin
        if (enable) begin
          next_state = RUN;
        end
      end
      RUN: begin
        if (!enable) begin
          next_state = IDLE;
        end
        wrap         = (half_cnt == div_active);
        update_event = wrap && (dac_clk || first_toggle);
      end
      default: next_state = IDLE;
    endcase
  end

  // div_active is reloaded only at a wrap so a DIV change never produces a
  // truncated half period. In IDLE it tracks configDac so the first period
  // after enabling uses the current setting.
  always_ff @(posedge clk) begin
    if (rst) begin
      half_cnt       <= '0;
      div_active     <= '0;
      first_toggle   <= 1'b1;
      dac_clk        <= 1'b0;
      dac_data       <= '0;
      sample_strobe  <= 1'b0;
      underrun       <= 1'b0;
      underrun_count <= '0;
    end else begin
      sample_strobe <= update_event;
      underrun      <= update_event && fifo_empty;
      if (state == IDLE) begin
        half_cnt     <= '0;
        div_active   <= div;
        first_toggle <= 1'b1;
        dac_clk      <= 1'b0;
        dac_data     <= offset;
      end else begin
        if (wrap) begin
          half_cnt     <= '0;
          div_active   <= div;
          first_toggle <= 1'b0;
          dac_clk      <= !dac_clk;
        end else begin
          half_cnt <= half_cnt + CFG_DIV_WIDTH'(1);
        end
        if (update_event) begin
          if (!fifo_empty) begin
            dac_data <= fifo_head + offset;
          end else begin
            if (underrun_count != 16'hFFFF) begin
              underrun_count <= underrun_count + 16'd1;
            end
            if (mode == UNDERRUN_OFFSET) begin
              dac_data <= offset;
            end
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_dac_ad9708_tx.sv
// Self-checking bench for dac_ad9708_tx.
// The reference model tracks elapsed cycles since RUN was entered and
// derives clock edges and update instants arithmetically from DIV, with the
// sample buffer held in a queue.
module tb_dac_ad9708_tx;

  localparam int W     = 12;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [W-1:0]  s_axis_tdata;
  logic          s_axis_tvalid;
  logic          s_axis_tready;
  logic [31:0]   configDac;
  logic          dac_clk;
  logic [W-1:0]  dac_data;
  logic          sample_strobe;
  logic          underrun;
  logic [15:0]   underrun_count;

  always #5 clk = ~clk;

  dac_ad9708_tx #(
    .DAC_DATA_WIDTH (W),
    .FIFO_DEPTH     (DEPTH)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .s_axis_tdata   (s_axis_tdata),
    .s_axis_tvalid  (s_axis_tvalid),
    .s_axis_tready  (s_axis_tready),
    .configDac      (configDac),
    .dac_clk        (dac_clk),
    .dac_data       (dac_data),
    .sample_strobe  (sample_strobe),
    .underrun       (underrun),
    .underrun_count (underrun_count)
  );

  // Reference model state (values the DUT should show after the last edge).
  bit           m_run;
  int           m_k;
  logic [W-1:0] m_q [$];
  logic [W-1:0] m_data;
  bit           m_clk;
  bit           m_strobe;
  bit           m_under;
  int           m_cnt;

  // Currently held stimulus.
  bit           g_rst;
  bit           g_en;
  bit           g_mode;
  logic [W-1:0] g_off;
  logic [7:0]   g_div;
  bit           g_valid;
  logic [W-1:0] g_data;
  bit           g_randData;

  int checks = 0;
  int fails  = 0;

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, actual, expected, $time);
    end
  endtask

  // One clock cycle: check what the last edge produced, drive this cycle's
  // inputs, then advance the model across the coming edge.
  task automatic applyStimulus(input bit r, input bit en, input bit mode,
                               input logic [W-1:0] off, input logic [7:0] div,
                               input bit valid, input logic [W-1:0] data);
    int           w;
    bit           ev;
    bit           wasEmpty;
    bit           wasFull;
    logic [W-1:0] head;
    logic [W-1:0] sum;
    logic [31:0]  cfg;
    @(negedge clk);
    checkOutput("dac_clk", 32'(dac_clk), 32'(m_clk));
    checkOutput("dac_data", 32'(dac_data), 32'(m_data));
    checkOutput("sample_strobe", 32'(sample_strobe), 32'(m_strobe));
    checkOutput("underrun", 32'(underrun), 32'(m_under));
    checkOutput("underrun_count", 32'(underrun_count), 32'(m_cnt));
    checkOutput("s_axis_tready", 32'(s_axis_tready), 32'(m_q.size() < DEPTH));

    cfg          = '0;
    cfg[31]      = en;
    cfg[30]      = mode;
    cfg[16 +: W] = off;
    cfg[7:0]     = div;
    rst           = r;
    configDac     = cfg;
    s_axis_tvalid = valid;
    s_axis_tdata  = data;

    if (r) begin
      m_run = 0; m_k = 0; m_q.delete(); m_data = '0; m_clk = 0;
      m_strobe = 0; m_under = 0; m_cnt = 0;
    end else begin
      wasEmpty = (m_q.size() == 0);
      wasFull  = (m_q.size() == DEPTH);
      ev       = 0;
      m_strobe = 0;
      m_under  = 0;
      if (m_run) begin
        if ((m_k + 1) % (int'(div) + 1) == 0) begin
          w     = (m_k + 1) / (int'(div) + 1);
          m_clk = w[0];
          ev    = (w == 1) || (w % 2 == 0);
        end
        m_k++;
      end else begin
        m_clk  = 0;
        m_data = off;
        m_k    = 0;
      end
      if (ev) begin
        m_strobe = 1;
        if (!wasEmpty) begin
          head   = m_q.pop_front();
          sum    = head + off;
          m_data = sum;
        end else begin
          m_under = 1;
          if (m_cnt < 65535) m_cnt++;
          if (mode) m_data = off;
        end
      end
      if (valid && !wasFull) m_q.push_back(data);
      m_run = en;
    end
  endtask

  task automatic stepCycles(input int n);
    for (int i = 0; i < n; i++) begin
      if (g_randData) begin
        g_valid = ($urandom_range(0, 2) != 0);
        g_data  = W'($urandom);
      end
      applyStimulus(g_rst, g_en, g_mode, g_off, g_div, g_valid, g_data);
    end
  endtask

  task automatic pushSample(input logic [W-1:0] d);
    g_valid = 1; g_data = d;
    stepCycles(1);
    g_valid = 0;
  endtask

  initial begin
    int len;
    rst = 1; configDac = '0; s_axis_tvalid = 0; s_axis_tdata = '0;
    m_run = 0; m_k = 0; m_data = '0; m_clk = 0; m_strobe = 0; m_under = 0; m_cnt = 0;
    g_rst = 1; g_en = 0; g_mode = 0; g_off = '0; g_div = 8'd1;
    g_valid = 0; g_data = '0; g_randData = 0;

    // Reset, then two samples at DIV=1 followed by starvation in both modes.
    stepCycles(3);
    g_rst = 0;
    pushSample(12'h123);
    pushSample(12'h456);
    stepCycles(2);
    g_en = 1;
    stepCycles(24);
    g_mode = 1;
    stepCycles(10);
    g_mode = 0; g_en = 0;
    stepCycles(3);

    // Offset addition wraps modulo 2^W.
    g_off = 12'h010; g_div = 8'd0;
    pushSample(12'hFF8);
    g_en = 1;
    stepCycles(6);
    g_en = 0;
    stepCycles(2);

    // Continuous tvalid: fills while disabled, drains once enabled.
    g_off = '0; g_randData = 0; g_valid = 1;
    for (int i = 0; i < 8; i++) begin
      g_data = W'($urandom);
      stepCycles(1);
    end
    g_en = 1;
    for (int i = 0; i < 20; i++) begin
      g_data = W'($urandom);
      stepCycles(1);
    end
    g_valid = 0; g_en = 0;
    stepCycles(3);

    // Reset mid-run with samples still buffered.
    g_div = 8'd3; g_off = 12'h005;
    for (int i = 0; i < 4; i++) pushSample(W'($urandom));
    g_en = 1;
    stepCycles(6);
    g_rst = 1;
    stepCycles(1);
    g_rst = 0; g_en = 0;
    stepCycles(6);
    pushSample(12'h0AB);
    g_en = 1;
    stepCycles(10);
    g_en = 0;
    stepCycles(2);

    // Underrun counter saturation, preloaded near the top.
    stepCycles(1);
    force dut.underrun_count = 16'hFFFD;
    m_cnt = 16'hFFFD;
    stepCycles(1);
    release dut.underrun_count;
    g_div = 8'd0; g_en = 1;
    stepCycles(14);
    g_en = 0;
    stepCycles(2);

    // Randomised enable segments with random data, offsets and modes.
    g_randData = 1;
    for (int s = 0; s < 24; s++) begin
      len = $urandom_range(4, 30);
      if ($urandom_range(0, 1) == 0) begin
        g_en = 0;
        stepCycles(1);
        g_div  = 8'($urandom_range(0, 3));
        g_mode = 1'($urandom_range(0, 1));
        g_off  = W'($urandom);
        stepCycles(len - 1);
      end else begin
        g_en   = 1;
        g_mode = 1'($urandom_range(0, 1));
        g_off  = W'($urandom);
        stepCycles(len);
      end
    end
    g_randData = 0; g_valid = 0; g_en = 0;
    stepCycles(3);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
